reservation_station: RTL and testbench
======================================

# reservation_station

Age-ordered reservation station that sits directly downstream of the source-operand mux in the out-of-order core. It accepts dispatched instructions whose two operands arrive in the 33-bit `{ready, data-or-tag}` format. Entries waiting on a tag capture the value from the common data bus (CDB) when it is broadcast. Each cycle the station issues the oldest entry whose operands are both ready to the execution unit through a valid/ready handshake.

## Interface
- `ENTRIES`, 4: number of station slots (≥2).
- `OP_W`, 6: width of the opaque operation field carried to the execution unit.
- `TAG_W`, 6: ROB tag width. Operand tags sit in bits [TAG_W-1:0] of a not-ready operand.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all entries (misprediction recovery).
- `dispatch_valid`  in  1  dispatch request.
- `dispatch_ready`  out  1  station can accept an entry this cycle.
- `dispatch_op`  in  OP_W  operation.
- `dispatch_dest_tag`  in  TAG_W  ROB tag of the instruction's result.
- `dispatch_src1`, `dispatch_src2`  in  33  operand format:
  - bit 32 = 1: value present in [31:0].
  - bit 32 = 0: awaiting the tag in [TAG_W-1:0], upper bits zero.
- `cdb_valid`  in  1  result broadcast this cycle.
- `cdb_tag`  in  TAG_W  tag of the broadcast result.
- `cdb_data`  in  32  broadcast value.
- `issue_valid`  out  1  an entry is ready to issue.
- `issue_ready`  in  1  execution unit accepts this cycle.
- `issue_op`  out  OP_W  operation of the issuing entry.
- `issue_dest_tag`  out  TAG_W  result tag of the issuing entry.
- `issue_src1`, `issue_src2`  out  32  operand values of the issuing entry.
- `count`  out  $clog2(ENTRIES+1)  number of occupied entries.

## Operation
- **Storage:** collapsing queue. Slot 0 is the oldest entry. Slots [0, count-1] are occupied.
- **Per-slot state:** op, dest_tag, and for each operand a rdy bit plus 32-bit val (val holds the tag while rdy=0).
- **Dispatch fire:** `dispatch_valid && dispatch_ready && !flush`. `dispatch_ready = (count < ENTRIES)`; it does not account for a simultaneous issue.
- **Dispatch bypass:** for each incoming operand with bit 32 = 0, if `cdb_valid` is high and `cdb_tag` matches the operand tag in the same cycle, the operand is stored with rdy=1 and val=`cdb_data`.
- **Wakeup:** every occupied slot's operand with rdy=0 and val[TAG_W-1:0]==`cdb_tag` gets rdy=1 and val=`cdb_data` at the clock edge when `cdb_valid` is high. Both operands of one slot may wake on the same broadcast.
- **Issue select:** `issue_valid` is high when some occupied slot has both rdy bits set. The selected slot is the lowest-index such slot. Selection is combinational from registered state only; a CDB broadcast in the current cycle does not make a slot issuable until the next cycle.
- **Issue outputs:** driven from the selected slot. They are all zero when `issue_valid`=0.
- **Issue fire:** `issue_valid && issue_ready && !flush`. The selected slot is removed, and every slot above it shifts down by one, carrying any wakeup applied this cycle.
- **Dispatch placement:**
  - Dispatch only: written at slot `count`.
  - Dispatch and issue in the same cycle: written at slot `count-1`, after the collapse.
- **Count update:** count changes by +1 on dispatch only, -1 on issue only, and 0 when both fire.
- **Flush:** count becomes 0 and all rdy bits clear at the next edge. `issue_valid` is forced to 0 during the flush cycle, and no dispatch is accepted in that cycle.

## Timing
- **Reset values:** count=0, all slots empty, `dispatch_ready`=1, `issue_valid`=0, all issue data outputs 0. Reset asserted mid-operation discards all entries immediately.
- **Ready-operand latency:** an entry dispatched with both operands ready at edge t is issuable in cycle t+1 (issue_valid high after the edge).
- **Wakeup latency:** a CDB broadcast in cycle t for the last missing operand makes that entry issuable in cycle t+1. The same applies to the dispatch-time bypass.
- **Stall:** while `issue_ready`=0, the selected entry and all outputs hold, unless an older entry becomes ready, in which case it preempts.
- **Full:** with count=ENTRIES, `dispatch_ready`=0 even if an issue fires that cycle. `dispatch_ready` returns to 1 one cycle after the issue.
- **Empty:** with count=0, `issue_valid`=0. A simultaneous dispatch is not visible until the next cycle.
- **Throughput:** one dispatch and one issue per cycle.

## Test plan
- **Reset and bypass:** reset, then dispatch op=5, dest=3, src1={1,0x10}, src2={1,0x20}. Require count=1 and, in the next cycle, issue_valid=1, issue_src1=0x10, issue_src2=0x20, issue_dest_tag=3. Pulse issue_ready and require count=0.
- **Wakeup:** dispatch src1={0,tag 7}, src2={1,0x1}. Hold issue_valid=0 for 3 cycles. Broadcast cdb tag 7, data 0xABCD. In the next cycle require issue_valid=1 and issue_src1=0xABCD.
- **Same-cycle CDB bypass:** dispatch with src2 awaiting tag 9 while cdb_valid is high with tag 9 and data 0x55. Require the entry to be issuable in the following cycle with issue_src2=0x55.
- **Age order:** fill 4 entries A–D, with B and D ready and A and C waiting. Require dispatch_ready=0 and issue order B then D. Wake A; require A issues before C. Check count at each step.
- **Full with simultaneous traffic:** with the station full, assert dispatch_valid and issue; require the dispatch to be refused. Next cycle, dispatch and issue together; require count unchanged and the new entry at the tail.
- **Flush and reset:** with 3 entries and issue_ready=0, assert flush. Require issue_valid=0 that cycle and count=0 after the edge. Repeat with an asynchronous reset asserted mid-cycle; require outputs to reach reset values immediately.

Source files
------------

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : reservation_station
// Description : Age-ordered collapsing reservation station with CDB wakeup,
//               dispatch-time CDB bypass and oldest-ready issue select.
// Revision    : 1.0 - initial release
// ============================================================================
module reservation_station #(
    parameter int ENTRIES = 4,
    parameter int OP_W    = 6,
    parameter int TAG_W   = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         dispatch_valid,
    output logic                         dispatch_ready,
    input  logic [OP_W-1:0]              dispatch_op,
    input  logic [TAG_W-1:0]             dispatch_dest_tag,
    input  logic [32:0]                  dispatch_src1,
    input  logic [32:0]                  dispatch_src2,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_data,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [OP_W-1:0]              issue_op,
    output logic [TAG_W-1:0]             issue_dest_tag,
    output logic [31:0]                  issue_src1,
    output logic [31:0]                  issue_src2,
    output logic [$clog2(ENTRIES+1)-1:0] count
);

    localparam int c_CNT_W = $clog2(ENTRIES + 1);
    localparam int c_IDX_W = $clog2(ENTRIES);

    logic [OP_W-1:0]    r_op   [ENTRIES];
    logic [TAG_W-1:0]   r_dest [ENTRIES];
    logic [31:0]        r_val1 [ENTRIES];
    logic [31:0]        r_val2 [ENTRIES];
    logic [ENTRIES-1:0] r_rdy1;
    logic [ENTRIES-1:0] r_rdy2;
    logic [c_CNT_W-1:0] r_count;

    logic [ENTRIES-1:0] w_occ;
    logic [ENTRIES-1:0] w_issuable;
    logic [ENTRIES-1:0] w_wk_rdy1;
    logic [ENTRIES-1:0] w_wk_rdy2;
    logic [31:0]        w_wk_val1 [ENTRIES];
    logic [31:0]        w_wk_val2 [ENTRIES];

    logic [OP_W-1:0]    w_n_op   [ENTRIES];
    logic [TAG_W-1:0]   w_n_dest [ENTRIES];
    logic [31:0]        w_n_val1 [ENTRIES];
    logic [31:0]        w_n_val2 [ENTRIES];
    logic [ENTRIES-1:0] w_n_rdy1;
    logic [ENTRIES-1:0] w_n_rdy2;
    logic [c_CNT_W-1:0] w_n_count;

    logic [c_IDX_W-1:0] w_sel;
    logic               w_any;
    logic               w_issue_fire;
    logic               w_dispatch_fire;
    logic [c_CNT_W-1:0] w_wr_idx;

    logic               w_d_m1, w_d_m2;
    logic               w_d_rdy1, w_d_rdy2;
    logic [31:0]        w_d_val1, w_d_val2;

    assign count          = r_count;
    assign dispatch_ready = (r_count < c_CNT_W'(ENTRIES));
    assign issue_valid    = w_any && !flush;

    assign w_issue_fire    = issue_valid && issue_ready;
    assign w_dispatch_fire = dispatch_valid && dispatch_ready && !flush;
    // With a simultaneous issue the queue collapses first, so the tail moves down.
    assign w_wr_idx        = w_issue_fire ? (r_count - c_CNT_W'(1)) : r_count;

    assign w_d_m1   = cdb_valid && !dispatch_src1[32] && (dispatch_src1[TAG_W-1:0] == cdb_tag);
    assign w_d_m2   = cdb_valid && !dispatch_src2[32] && (dispatch_src2[TAG_W-1:0] == cdb_tag);
    assign w_d_rdy1 = dispatch_src1[32] || w_d_m1;
    assign w_d_rdy2 = dispatch_src2[32] || w_d_m2;
    assign w_d_val1 = w_d_m1 ? cdb_data : dispatch_src1[31:0];
    assign w_d_val2 = w_d_m2 ? cdb_data : dispatch_src2[31:0];

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
        logic w_m1, w_m2;
        assign w_m1 = cdb_valid && !r_rdy1[gi] && (r_val1[gi][TAG_W-1:0] == cdb_tag);
        assign w_m2 = cdb_valid && !r_rdy2[gi] && (r_val2[gi][TAG_W-1:0] == cdb_tag);
        assign w_wk_rdy1[gi]  = r_rdy1[gi] || w_m1;
        assign w_wk_rdy2[gi]  = r_rdy2[gi] || w_m2;
        assign w_wk_val1[gi]  = w_m1 ? cdb_data : r_val1[gi];
        assign w_wk_val2[gi]  = w_m2 ? cdb_data : r_val2[gi];
        assign w_occ[gi]      = (c_CNT_W'(gi) < r_count);
        assign w_issuable[gi] = w_occ[gi] && r_rdy1[gi] && r_rdy2[gi];
    end

    // Oldest-first: scan downward so the lowest ready index wins.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_issuable[i]) begin
                w_sel = c_IDX_W'(i);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        issue_op       = '0;
        issue_dest_tag = '0;
        issue_src1     = '0;
        issue_src2     = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (issue_valid && (w_sel == c_IDX_W'(i))) begin
                issue_op       = r_op[i];
                issue_dest_tag = r_dest[i];
                issue_src1     = r_val1[i];
                issue_src2     = r_val2[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_n_op[i]   = r_op[i];
            w_n_dest[i] = r_dest[i];
            w_n_val1[i] = w_wk_val1[i];
            w_n_val2[i] = w_wk_val2[i];
            w_n_rdy1[i] = w_wk_rdy1[i];
            w_n_rdy2[i] = w_wk_rdy2[i];
        end
        if (w_issue_fire) begin
            for (int i = 0; i < ENTRIES - 1; i++) begin
                if (c_IDX_W'(i) >= w_sel) begin
                    w_n_op[i]   = r_op[i+1];
                    w_n_dest[i] = r_dest[i+1];
                    w_n_val1[i] = w_wk_val1[i+1];
                    w_n_val2[i] = w_wk_val2[i+1];
                    w_n_rdy1[i] = w_wk_rdy1[i+1];
                    w_n_rdy2[i] = w_wk_rdy2[i+1];
                end
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_dispatch_fire && (c_CNT_W'(i) == w_wr_idx)) begin
                w_n_op[i]   = dispatch_op;
                w_n_dest[i] = dispatch_dest_tag;
                w_n_val1[i] = w_d_val1;
                w_n_val2[i] = w_d_val2;
                w_n_rdy1[i] = w_d_rdy1;
                w_n_rdy2[i] = w_d_rdy2;
            end
        end
    end

    always_comb begin
        case ({w_dispatch_fire, w_issue_fire})
            2'b10:   w_n_count = r_count + c_CNT_W'(1);
            2'b01:   w_n_count = r_count - c_CNT_W'(1);
            default: w_n_count = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_op[i]   <= '0;
                r_dest[i] <= '0;
                r_val1[i] <= '0;
                r_val2[i] <= '0;
            end
        end else if (flush) begin
            r_count <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
        end else begin
            r_count <= w_n_count;
            r_rdy1  <= w_n_rdy1;
            r_rdy2  <= w_n_rdy2;
            for (int i = 0; i < ENTRIES; i++) begin
                r_op[i]   <= w_n_op[i];
                r_dest[i] <= w_n_dest[i];
                r_val1[i] <= w_n_val1[i];
                r_val2[i] <= w_n_val2[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_reservation_station
// Description : Directed vector table, flush/reset sequences and a random run
//               against a queue-based reference model of the station.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

    localparam int ENTRIES = 4;

    logic        clk = 1'b0;
    logic        reset, flush, dispatch_valid, dispatch_ready;
    logic [5:0]  dispatch_op, dispatch_dest_tag;
    logic [32:0] dispatch_src1, dispatch_src2;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid, issue_ready;
    logic [5:0]  issue_op, issue_dest_tag;
    logic [31:0] issue_src1, issue_src2;
    logic [2:0]  count;

    always #5 clk = ~clk;

    reservation_station #(.ENTRIES(ENTRIES), .OP_W(6), .TAG_W(6)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op(dispatch_op), .dispatch_dest_tag(dispatch_dest_tag),
        .dispatch_src1(dispatch_src1), .dispatch_src2(dispatch_src2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dest_tag(issue_dest_tag),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .count(count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        dv;
        logic [5:0]  op, dest;
        logic [32:0] s1, s2;
        logic        cv;
        logic [5:0]  ctag;
        logic [31:0] cdata;
        logic        ir;
        logic [80:0] exp;
    } vec_t;

    typedef struct {
        logic [5:0]  op, dest;
        logic        r1, r2;
        logic [31:0] v1, v2;
    } ent_t;

    vec_t vecs[$];
    ent_t q[$];

    function automatic logic [32:0] R(input int v);
        return {1'b1, 32'(v)};
    endfunction

    function automatic logic [32:0] W(input int t);
        return {1'b0, 26'd0, 6'(t)};
    endfunction

    // {dispatch_ready, issue_valid, count, op, dest, src1, src2}
    function automatic logic [80:0] pk(input int dr, iv, c, op, dest, s1, s2);
        return {1'(dr), 1'(iv), 3'(c), 6'(op), 6'(dest), 32'(s1), 32'(s2)};
    endfunction

    function automatic logic [80:0] act();
        return {dispatch_ready, issue_valid, count, issue_op, issue_dest_tag, issue_src1, issue_src2};
    endfunction

    task automatic chk(input string nm, input logic [80:0] a, input logic [80:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got dr=%b iv=%b cnt=%0d op=%h dst=%h s1=%h s2=%h, expected dr=%b iv=%b cnt=%0d op=%h dst=%h s1=%h s2=%h",
                      nm, a[80], a[79], a[78:76], a[75:70], a[69:64], a[63:32], a[31:0],
                      e[80], e[79], e[78:76], e[75:70], e[69:64], e[63:32], e[31:0]);
    endtask

    task automatic add(input int dv, op, dest, input logic [32:0] s1, s2,
                       input int cv, ctag, cdata, ir,
                       input int edr, eiv, ecnt, eop, edest, es1, es2);
        vec_t x;
        x.dv = 1'(dv); x.op = 6'(op); x.dest = 6'(dest); x.s1 = s1; x.s2 = s2;
        x.cv = 1'(cv); x.ctag = 6'(ctag); x.cdata = 32'(cdata); x.ir = 1'(ir);
        x.exp = pk(edr, eiv, ecnt, eop, edest, es1, es2);
        vecs.push_back(x);
    endtask

    task automatic idle_in();
        flush = 1'b0; dispatch_valid = 1'b0; dispatch_op = '0; dispatch_dest_tag = '0;
        dispatch_src1 = '0; dispatch_src2 = '0; cdb_valid = 1'b0; cdb_tag = '0;
        cdb_data = '0; issue_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic fill3();
        for (int k = 0; k < 3; k++) begin
            dispatch_valid = 1'b1; dispatch_op = 6'(k + 1); dispatch_dest_tag = 6'(k + 8);
            dispatch_src1 = R(k + 100); dispatch_src2 = R(k + 200);
            @(posedge clk); #1;
        end
        idle_in();
    endtask

    int          sel;
    logic        eiv, ifire, dfire, m1, m2;
    logic [80:0] e;
    ent_t        ne;

    initial begin
        reset = 1'b0;
        // inputs: dv op dest s1 s2 cv ctag cdata ir | expected: dr iv cnt op dest s1 s2
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,                      1, 0, 0, 0, 0, 0, 0);
        add(1, 5, 3, R('h10), R('h20), 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,                      1, 1, 1, 5, 3, 'h10, 'h20);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,                      1, 1, 1, 5, 3, 'h10, 'h20);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,                      1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4, W(7), R(1), 0, 0, 0, 0,                1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,                      1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 7, 'hABCD, 0,                 1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,                      1, 1, 1, 1, 4, 'hABCD, 1);
        add(1, 2, 5, R(2), W(9), 1, 9, 'h55, 0,             1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,                      1, 1, 1, 2, 5, 2, 'h55);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,                      1, 0, 0, 0, 0, 0, 0);
        add(1, 'hA, 20, W(10), R('hA2), 0, 0, 0, 0,         1, 0, 0, 0, 0, 0, 0);
        add(1, 'hB, 21, R('hB1), R('hB2), 0, 0, 0, 0,       1, 0, 1, 0, 0, 0, 0);
        add(1, 'hC, 22, R('hC1), W(11), 0, 0, 0, 0,         1, 1, 2, 'hB, 21, 'hB1, 'hB2);
        add(1, 'hD, 23, R('hD1), R('hD2), 0, 0, 0, 0,       1, 1, 3, 'hB, 21, 'hB1, 'hB2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,                      0, 1, 4, 'hB, 21, 'hB1, 'hB2);
        add(1, 'hE, 24, R('hE1), R('hE2), 0, 0, 0, 1,       0, 1, 4, 'hB, 21, 'hB1, 'hB2);
        add(1, 'hE, 24, R('hE1), R('hE2), 0, 0, 0, 1,       1, 1, 3, 'hD, 23, 'hD1, 'hD2);
        add(0, 0, 0, 0, 0, 1, 10, 'h1234, 0,                1, 1, 3, 'hE, 24, 'hE1, 'hE2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,                      1, 1, 3, 'hA, 20, 'h1234, 'hA2);
        add(0, 0, 0, 0, 0, 1, 11, 'h77, 1,                  1, 1, 2, 'hE, 24, 'hE1, 'hE2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1,                      1, 1, 1, 'hC, 22, 'hC1, 'h77);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,                      1, 0, 0, 0, 0, 0, 0);

        do_reset();
        foreach (vecs[k]) begin
            flush = 1'b0;
            dispatch_valid = vecs[k].dv; dispatch_op = vecs[k].op; dispatch_dest_tag = vecs[k].dest;
            dispatch_src1 = vecs[k].s1; dispatch_src2 = vecs[k].s2;
            cdb_valid = vecs[k].cv; cdb_tag = vecs[k].ctag; cdb_data = vecs[k].cdata;
            issue_ready = vecs[k].ir;
            @(negedge clk);
            chk($sformatf("vec%0d", k), act(), vecs[k].exp);
            @(posedge clk); #1;
        end

        // Flush with three stalled entries; the concurrent dispatch must be dropped.
        do_reset();
        fill3();
        @(negedge clk);
        chk("flush_pre", act(), pk(1, 1, 3, 1, 8, 100, 200));
        @(posedge clk); #1;
        flush = 1'b1; dispatch_valid = 1'b1; dispatch_src1 = R(5); dispatch_src2 = R(6);
        @(negedge clk);
        chk("flush_cycle", act(), pk(1, 0, 3, 0, 0, 0, 0));
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("flush_after", act(), pk(1, 0, 0, 0, 0, 0, 0));

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk); #1;
        fill3();
        @(negedge clk);
        chk("areset_pre", act(), pk(1, 1, 3, 1, 8, 100, 200));
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("areset_now", act(), pk(1, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("areset_after", act(), pk(1, 0, 0, 0, 0, 0, 0));

        // Randomized traffic against the reference model.
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            flush          = ($urandom_range(0, 39) == 0);
            dispatch_valid = ($urandom_range(0, 9) < 6);
            issue_ready    = ($urandom_range(0, 9) < 6);
            dispatch_op       = 6'($urandom);
            dispatch_dest_tag = 6'($urandom);
            dispatch_src1 = $urandom_range(0, 1) ? R(int'($urandom)) : W(int'($urandom_range(0, 7)));
            dispatch_src2 = $urandom_range(0, 1) ? R(int'($urandom)) : W(int'($urandom_range(0, 7)));
            cdb_valid = ($urandom_range(0, 9) < 4);
            cdb_tag   = 6'($urandom_range(0, 7));
            cdb_data  = $urandom;

            sel = -1;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].r1 && q[i].r2) sel = i;
            eiv = !flush && (sel >= 0);
            if (eiv) e = pk(q.size() < ENTRIES, 1, q.size(), q[sel].op, q[sel].dest, q[sel].v1, q[sel].v2);
            else     e = pk(q.size() < ENTRIES, 0, q.size(), 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("rand%0d", cyc), act(), e);

            ifire = eiv && issue_ready;
            dfire = dispatch_valid && (q.size() < ENTRIES) && !flush;
            if (flush) q.delete();
            else begin
                foreach (q[i]) begin
                    if (cdb_valid && !q[i].r1 && q[i].v1[5:0] == cdb_tag) begin q[i].r1 = 1'b1; q[i].v1 = cdb_data; end
                    if (cdb_valid && !q[i].r2 && q[i].v2[5:0] == cdb_tag) begin q[i].r2 = 1'b1; q[i].v2 = cdb_data; end
                end
                if (ifire) q.delete(sel);
                if (dfire) begin
                    m1 = cdb_valid && !dispatch_src1[32] && dispatch_src1[5:0] == cdb_tag;
                    m2 = cdb_valid && !dispatch_src2[32] && dispatch_src2[5:0] == cdb_tag;
                    ne.op = dispatch_op; ne.dest = dispatch_dest_tag;
                    ne.r1 = dispatch_src1[32] || m1; ne.v1 = m1 ? cdb_data : dispatch_src1[31:0];
                    ne.r2 = dispatch_src2[32] || m2; ne.v2 = m2 ? cdb_data : dispatch_src2[31:0];
                    q.push_back(ne);
                end
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
